// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: core (priority) vs. ext loader/debug port.
// Same-cycle grant, one-cycle read latency, starvation and burst bounds.
module dmem_arbiter #(
   parameter int ADDR_W    = 12,
   parameter int MAX_WAIT  = 4,
   parameter int BURST_MAX = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_req,
   input  logic [3:0]        core_we,
   input  logic [ADDR_W-1:0] core_adr,
   input  logic [31:0]       core_wdata,
   output logic              core_gnt,
   output logic              core_stall,
   output logic              core_rvalid,
   output logic [31:0]       core_rdata,
   input  logic              ext_req,
   input  logic              ext_lock,
   input  logic [3:0]        ext_we,
   input  logic [ADDR_W-1:0] ext_adr,
   input  logic [31:0]       ext_wdata,
   output logic              ext_gnt,
   output logic              ext_rvalid,
   output logic [31:0]       ext_rdata,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam int BW = $clog2(BURST_MAX + 1);

   typedef enum logic {ARB = 1'b0, BURST = 1'b1} state_t;

   state_t        state;
   state_t        state_nx;
   logic [WW-1:0] wait_cnt;
   logic [BW-1:0] burst_cnt;
   logic          rv_core;
   logic          rv_ext;
   logic          force_ext;
   logic          burst_last;

   assign force_ext  = ext_req && (wait_cnt == WW'(MAX_WAIT));
   // Current burst grant is the BURST_MAX-th one; leave after it.
   assign burst_last = burst_cnt >= BW'(BURST_MAX - 1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ARB;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ARB: begin
            if (ext_gnt && ext_lock && (BURST_MAX > 1))
               state_nx = BURST;
         end
         BURST: begin
            if (!ext_req || !ext_lock || burst_last)
               state_nx = ARB;
         end
         default: state_nx = ARB;
      endcase
   end

   always_comb begin
      core_gnt = 1'b0;
      ext_gnt  = 1'b0;
      case (state)
         ARB: begin
            if (force_ext)     ext_gnt  = 1'b1;
            else if (core_req) core_gnt = 1'b1;
            else               ext_gnt  = ext_req;
         end
         BURST:   ext_gnt = ext_req;
         default: ;
      endcase
   end

   always_comb begin
      mem_we    = '0;
      mem_adr   = '0;
      mem_wdata = '0;
      if (core_gnt) begin
         mem_we    = core_we;
         mem_adr   = core_adr;
         mem_wdata = core_wdata;
      end else if (ext_gnt) begin
         mem_we    = ext_we;
         mem_adr   = ext_adr;
         mem_wdata = ext_wdata;
      end
   end

   assign mem_en     = core_gnt | ext_gnt;
   assign core_stall = core_req & ~core_gnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt  <= '0;
         burst_cnt <= '0;
         rv_core   <= 1'b0;
         rv_ext    <= 1'b0;
      end else begin
         if (ext_req && !ext_gnt) begin
            if (wait_cnt != WW'(MAX_WAIT))
               wait_cnt <= wait_cnt + WW'(1);
         end else begin
            wait_cnt <= '0;
         end
         if (state_nx == BURST)
            burst_cnt <= (state == ARB) ? BW'(1) : burst_cnt + BW'(1);
         else
            burst_cnt <= '0;
         rv_core <= core_gnt && (core_we == 4'b0000);
         rv_ext  <= ext_gnt && (ext_we == 4'b0000);
      end
   end

   assign core_rvalid = rv_core;
   assign ext_rvalid  = rv_ext;
   assign core_rdata  = mem_rdata;
   assign ext_rdata   = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: priority, starvation, bursts,
// writes, async reset and idle behaviour.
module tb_dmem_arbiter;

   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          reset;
   logic          core_req;
   logic [3:0]    core_we;
   logic [AW-1:0] core_adr;
   logic [31:0]   core_wdata;
   logic          core_gnt;
   logic          core_stall;
   logic          core_rvalid;
   logic [31:0]   core_rdata;
   logic          ext_req;
   logic          ext_lock;
   logic [3:0]    ext_we;
   logic [AW-1:0] ext_adr;
   logic [31:0]   ext_wdata;
   logic          ext_gnt;
   logic          ext_rvalid;
   logic [31:0]   ext_rdata;
   logic          mem_en;
   logic [3:0]    mem_we;
   logic [AW-1:0] mem_adr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   int checks   = 0;
   int failures = 0;

   dmem_arbiter #(.ADDR_W(AW), .MAX_WAIT(4), .BURST_MAX(8)) dut (
      .clk(clk), .reset(reset),
      .core_req(core_req), .core_we(core_we), .core_adr(core_adr),
      .core_wdata(core_wdata), .core_gnt(core_gnt),
      .core_stall(core_stall), .core_rvalid(core_rvalid),
      .core_rdata(core_rdata),
      .ext_req(ext_req), .ext_lock(ext_lock), .ext_we(ext_we),
      .ext_adr(ext_adr), .ext_wdata(ext_wdata), .ext_gnt(ext_gnt),
      .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change just after the falling edge.
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle();
      core_req = 0; core_we = 0; core_adr = 0; core_wdata = 0;
      ext_req = 0; ext_lock = 0; ext_we = 0; ext_adr = 0; ext_wdata = 0;
   endtask

   initial begin
      idle();
      mem_rdata = 32'h0;
      reset = 1'b0;
      #1;
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_rv", {30'd0, core_rvalid, ext_rvalid}, 0);
      chk("rst_wait", 32'(dut.wait_cnt), 0);
      chk("rst_state", 32'(dut.state), 0);
      cyc(); cyc();
      reset = 1'b1;
      cyc();

      // Idle: nothing issued, nothing stalled
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("idle_out", {27'd0, mem_en, core_gnt, ext_gnt, core_stall,
                          1'b0}, 0);
         chk("idle_we", 32'(mem_we), 0);
         cyc();
      end

      // Core read, data one cycle later
      core_req = 1; core_adr = 12'h010;
      #1;
      chk("t1_gnt", {29'd0, core_gnt, ext_gnt, core_stall}, 32'b100);
      chk("t1_mem", {27'd0, mem_en, mem_we}, 32'h10);
      chk("t1_adr", 32'(mem_adr), 32'h010);
      cyc();
      idle();
      mem_rdata = 32'hDEADBEEF;
      #1;
      chk("t1_rv", {30'd0, core_rvalid, ext_rvalid}, 32'b10);
      chk("t1_rdata", core_rdata, 32'hDEADBEEF);
      cyc();
      #1;
      chk("t1_rv_drop", 32'(core_rvalid), 0);
      cyc();

      // Contention: ext forced in after MAX_WAIT denied cycles
      core_req = 1; ext_req = 1;
      core_adr = 12'h020; ext_adr = 12'h030;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk($sformatf("t2_c%0d", i), {29'd0, core_gnt, ext_gnt, core_stall},
             (i == 4) ? 32'b011 : 32'b100);
         if (i == 5) begin
            chk("t2_wait0", 32'(dut.wait_cnt), 0);
            chk("t2_ext_rv", {30'd0, core_rvalid, ext_rvalid}, 32'b01);
         end
         cyc();
      end
      idle();
      cyc();

      // Locked burst capped at 8, one core slot, then ext re-enters
      ext_req = 1; ext_lock = 1; ext_adr = 12'h100;
      for (int i = 0; i < 10; i++) begin
         core_req = (i >= 1 && i <= 8);
         #1;
         chk($sformatf("t3_c%0d", i), {30'd0, core_gnt, ext_gnt},
             (i == 8) ? 32'b10 : 32'b01);
         if (i >= 1 && i <= 7)
            chk($sformatf("t3_stall%0d", i), 32'(core_stall), 1);
         cyc();
      end
      #1;
      chk("t3_reenter", 32'(dut.state), 1);
      chk("t3_bcnt", 32'(dut.burst_cnt), 1);
      idle();
      cyc(); cyc();

      // Ext partial write to top address
      ext_req = 1; ext_we = 4'b0011; ext_adr = 12'hFFF;
      ext_wdata = 32'h1234ABCD;
      #1;
      chk("t4_gnt", 32'(ext_gnt), 1);
      chk("t4_mem", {27'd0, mem_en, mem_we}, 32'h13);
      chk("t4_adr", 32'(mem_adr), 32'hFFF);
      chk("t4_wdata", mem_wdata, 32'h1234ABCD);
      cyc();
      idle();
      #1;
      chk("t4_no_rv", {30'd0, core_rvalid, ext_rvalid}, 0);
      cyc();

      // Async reset mid-burst with an ext read in flight
      ext_req = 1; ext_lock = 1; ext_adr = 12'h200;
      cyc(); cyc(); cyc();
      #1;
      chk("t5_pre_bcnt", 32'(dut.burst_cnt), 3);
      chk("t5_pre_rv", 32'(ext_rvalid), 1);
      idle();
      reset = 1'b0;
      #1;
      chk("t5_rv", 32'(ext_rvalid), 0);
      chk("t5_state", 32'(dut.state), 0);
      chk("t5_cnts", {16'(dut.wait_cnt), 16'(dut.burst_cnt)}, 0);
      cyc();
      reset = 1'b1;
      cyc();
      #1;
      chk("t5_no_replay", {29'd0, ext_rvalid, mem_en, ext_gnt}, 0);
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
